// File: rtl/mul_add_sched_pkg.sv
// Shared types and helpers for the multiply-add round-robin scheduler.
package mul_add_sched_pkg;

    localparam int unsigned DATA_W_DEFAULT   = 32;
    localparam int unsigned PIPE_LAT_DEFAULT = 3;
    localparam int unsigned MAX_REQ          = 8;
    localparam int unsigned TAG_ID_W         = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // One-hot grant: first set bit of valid searching upward from ptr+1, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                   input logic [TAG_ID_W-1:0] ptr,
                                                   input int unsigned         n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [3:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !found) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'(n)) begin
                    idx = idx - 4'(n);
                end
                if (valid[idx[2:0]]) begin
                    grant[idx[2:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mul_add_resp_fifo.sv
// Circular response FIFO; depth need not be a power of two. Head is shown combinationally.
module mul_add_resp_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    // Empty head reads as zero so stale entries never leak out.
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wrap_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= wrap_inc(rd_q);
            end
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/mul_add_rr_scheduler.sv
// Credit-gated round-robin front end sharing one multiply-add pipeline among NUM_REQ requesters.
// Optional statistics counters are enabled by defining MUL_ADD_SCHED_STATS_EN.
module mul_add_rr_scheduler
    import mul_add_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned PIPE_LAT   = PIPE_LAT_DEFAULT,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_x,
    input  logic [NUM_REQ*DATA_W-1:0]    req_y,
    input  logic [NUM_REQ*DATA_W-1:0]    req_z,
    output logic [DATA_W-1:0]            mac_x,
    output logic [DATA_W-1:0]            mac_y,
    output logic [DATA_W-1:0]            mac_z,
    input  logic [DATA_W-1:0]            mac_out,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [DATA_W-1:0]            resp_data
`ifdef MUL_ADD_SCHED_STATS_EN
    , output logic [NUM_REQ*16-1:0]      stat_grants,
    output logic [15:0]                  stat_credit_stall
`endif
);

    localparam int unsigned ID_W       = $clog2(NUM_REQ);
    localparam int unsigned FIFO_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OUT_W      = $clog2(RESP_DEPTH + PIPE_LAT + 1);

    tag_t                   tags_q [PIPE_LAT];
    tag_t                   tail_tag;
    logic [TAG_ID_W-1:0]    tail_id_unused;
    logic [ID_W-1:0]        rr_ptr_q, gnt_idx;
    logic [MAX_REQ-1:0]     pick;
    logic [NUM_REQ-1:0]     grant;
    logic                   can_issue, issue;
    logic [OUT_W-1:0]       outstanding;
    logic [FIFO_CNT_W-1:0]  fifo_count;
    logic                   fifo_full_unused, fifo_empty, fifo_pop;
    logic [ID_W+DATA_W-1:0] fifo_head;

    // Credits cover everything issued but not yet popped, so the pipeline can never overrun.
    always_comb begin
        outstanding = OUT_W'(fifo_count);
        for (int i = 0; i < PIPE_LAT; i++) begin
            outstanding = outstanding + OUT_W'(tags_q[i].valid);
        end
    end

    assign can_issue = (outstanding < OUT_W'(RESP_DEPTH)) && !rst;
    assign pick      = rr_pick(MAX_REQ'(req_valid), TAG_ID_W'(rr_ptr_q), NUM_REQ);
    assign grant     = pick[NUM_REQ-1:0];
    assign req_ready = {NUM_REQ{can_issue}} & grant;
    assign issue     = |req_ready;

    always_comb begin
        gnt_idx = '0;
        mac_x   = '0;
        mac_y   = '0;
        mac_z   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = ID_W'(i);
                mac_x   = req_x[i*DATA_W +: DATA_W];
                mac_y   = req_y[i*DATA_W +: DATA_W];
                mac_z   = req_z[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            for (int i = 0; i < PIPE_LAT; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            tags_q[0] <= '{valid: issue, id: TAG_ID_W'(gnt_idx)};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tags_q[i] <= tags_q[i-1];
            end
            if (issue) begin
                rr_ptr_q <= gnt_idx;
            end
        end
    end

    assign tail_tag       = tags_q[PIPE_LAT-1];
    assign tail_id_unused = tail_tag.id;
    assign fifo_pop       = resp_valid && resp_ready;

    mul_add_resp_fifo #(
        .WIDTH (ID_W + DATA_W),
        .DEPTH (RESP_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tail_tag.valid),
        .push_data_i ({ID_W'(tail_tag.id), mac_out}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full_unused),
        .empty_o     (fifo_empty)
    );

    assign resp_valid             = !fifo_empty;
    assign {resp_id, resp_data}   = fifo_head;

`ifdef MUL_ADD_SCHED_STATS_EN
    logic [15:0] grants_q [NUM_REQ];
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && grants_q[i] != 16'hFFFF) begin
                    grants_q[i] <= grants_q[i] + 16'd1;
                end
            end
            if (|req_valid && !can_issue && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grants_q[i];
        end
    end

    assign stat_credit_stall = stall_q;
`endif

endmodule

// File: tb/tb_mul_add_rr_scheduler.sv
// Randomised bench for mul_add_rr_scheduler with a queue-based reference model.
module tb_mul_add_rr_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 32;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid, req_ready;
    logic [N*W-1:0]   req_x, req_y, req_z;
    logic [W-1:0]     mac_x, mac_y, mac_z, mac_out;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_data;
`ifdef MUL_ADD_SCHED_STATS_EN
    logic [N*16-1:0]  stat_grants;
    logic [15:0]      stat_credit_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mul_add_rr_scheduler #(
        .NUM_REQ    (N),
        .DATA_W     (W),
        .PIPE_LAT   (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_z      (req_z),
        .mac_x      (mac_x),
        .mac_y      (mac_y),
        .mac_z      (mac_z),
        .mac_out    (mac_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
`ifdef MUL_ADD_SCHED_STATS_EN
        , .stat_grants       (stat_grants),
        .stat_credit_stall (stat_credit_stall)
`endif
    );

    // Free-running datapath: x*y+z appears LAT cycles after the operands.
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mac_x * mac_y + mac_z;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_out = pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        int          id;
        logic [W-1:0] data;
        int          avail;
    } resp_t;

    resp_t q[$];
    int    m_out = 0;
    int    m_ptr = N - 1;
`ifdef MUL_ADD_SCHED_STATS_EN
    int    m_gr [N] = '{default: 0};
    int    m_st = 0;
`endif

    always @(negedge clk) begin : cmp
        logic [N-1:0] exp_ready;
        logic [W-1:0] ex, ey, ez;
        logic [63:0]  full;
        int           g, c;
        bit           exp_rv;
        resp_t        r;
        cyc++;
        exp_ready = '0;
        g = -1;
        if (!rst && m_out < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        check("req_ready", req_ready, exp_ready);
        ex = '0; ey = '0; ez = '0;
        if (exp_ready != '0) begin
            ex = req_x[g*W +: W];
            ey = req_y[g*W +: W];
            ez = req_z[g*W +: W];
        end
        check("mac_x", mac_x, ex);
        check("mac_y", mac_y, ey);
        check("mac_z", mac_z, ez);
        exp_rv = (q.size() > 0) && (q[0].avail <= cyc);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check("resp_id", resp_id, q[0].id);
            check("resp_data", resp_data, q[0].data);
        end
`ifdef MUL_ADD_SCHED_STATS_EN
        for (int i = 0; i < N; i++) check("stat_grants", stat_grants[i*16 +: 16], m_gr[i]);
        check("stat_credit_stall", stat_credit_stall, m_st);
        if (rst) begin
            m_gr = '{default: 0};
            m_st = 0;
        end else begin
            if (exp_ready != '0 && m_gr[g] < 65535) m_gr[g]++;
            if (|req_valid && m_out >= DEPTH && m_st < 65535) m_st++;
        end
`endif
        if (rst) begin
            q.delete();
            m_out = 0;
            m_ptr = N - 1;
        end else begin
            if (exp_rv && resp_ready) begin
                void'(q.pop_front());
                m_out--;
            end
            if (exp_ready != '0) begin
                full    = 64'(ex) * 64'(ey) + 64'(ez);
                r.id    = g;
                r.data  = full[W-1:0];
                r.avail = cyc + LAT + 1;
                q.push_back(r);
                m_out++;
                m_ptr = g;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] dut_hs = '0;
    always @(negedge clk) dut_hs <= req_valid & req_ready;

    logic [N-1:0] v = '0;
    logic [W-1:0] ox [N], oy [N], oz [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = ox[i];
            req_y[i*W +: W] = oy[i];
            req_z[i*W +: W] = oz[i];
        end
        req_valid = v;
    endtask

    // Requesters still waiting keep valid and operands stable.
    task automatic step(input logic [N-1:0] want);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!(v[i] && !dut_hs[i])) begin
                v[i]  = want[i];
                ox[i] = $urandom;
                oy[i] = $urandom;
                oz[i] = $urandom;
            end
        end
        apply();
    endtask

    task automatic directed(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] z, input logic [W-1:0] exp);
        logic [N-1:0] one;
        one = 1;
        @(posedge clk);
        #1;
        v = '0;
        v[i] = 1'b1;
        ox[i] = x; oy[i] = y; oz[i] = z;
        apply();
        #1 check("dir_ready", req_ready, one << i);
        @(posedge clk);
        #1;
        v = '0;
        apply();
        repeat (2) @(posedge clk);
        #1 check("dir_not_early", resp_valid, 0);
        @(posedge clk);
        #1;
        check("dir_resp_valid", resp_valid, 1);
        check("dir_resp_id", resp_id, i);
        check("dir_resp_data", resp_data, exp);
    endtask

    initial begin : stim
        int issues, prev, id;
        for (int i = 0; i < N; i++) begin
            ox[i] = '0; oy[i] = '0; oz[i] = '0;
        end
        apply();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_id", resp_id, 0);
        check("reset_resp_data", resp_data, 0);
        check("reset_req_ready", req_ready, 0);

        directed(2, 32'd3, 32'd5, 32'd7, 32'd22);
        directed(1, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001);
        directed(3, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'd5);

        // All requesters valid: grants rotate strictly through the IDs.
        prev = -1;
        repeat (40) begin
            step(4'b1111);
            if (dut_hs != '0) begin
                id = $clog2(dut_hs);
                if (prev >= 0) check("rr_order", id, (prev + 1) % N);
                prev = id;
            end
        end
        repeat (10) step('0);

        // Flood with consumer stalled: credits cap issues at DEPTH.
        resp_ready = 1'b0;
        issues = 0;
        repeat (12) begin
            step(4'b0011);
            issues += $countones(dut_hs);
        end
        #1;
        check("flood_issue_count", issues, DEPTH);
        check("flood_blocked", req_ready, 0);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        #1 check("flood_pop_same_cycle", req_ready, 0);
        @(posedge clk);
        #1 check("flood_credit_next", |req_ready, 1);
        repeat (20) step(4'b0011);
        repeat (10) step('0);

        // Reset with two responses queued and two ops in flight.
        resp_ready = 1'b0;
        step(4'b0010);
        step(4'b0010);
        repeat (4) step('0);
        step(4'b1000);
        step(4'b1000);
        step('0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_flush_resp_valid", resp_valid, 0);
        resp_ready = 1'b1;
        step(4'b1111);
        #1 check("rst_first_winner", req_ready, 4'b0001);
        repeat (15) step(4'b1111);
        repeat (10) step('0);

        // Randomised traffic, back-pressure and occasional reset.
        repeat (400) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step(4'($urandom));
        end
        rst = 1'b0;
        repeat (12) step('0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
